// File: rtl/multdiv_divider_pkg.sv
// rtl/multdiv_divider_pkg.sv - shared widths, iteration count and FSM encoding for the divider
package multdiv_divider_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude as unsigned; -2^31 maps to 32'h80000000, which the datapath handles as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step (shift, trial subtract, quotient bit)
module div_step
  import multdiv_divider_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem < divisor <= 2^31 keeps the shifted remainder below 2^32, so bit DATA_W of trial is its sign.
  assign shifted = {rem_in, quo_in[DATA_W-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign rem_out = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_out = {quo_in[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/multdiv_divider.sv
// rtl/multdiv_divider.sv - 32-bit signed restoring divider, one step per clock, divide-by-zero flag
module multdiv_divider
  import multdiv_divider_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_div,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              negate;
  logic              div_zero;
  logic              b_zero;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  assign b_zero = (data_operandB == '0);

  div_step u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (divisor),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      negate         <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      // A start in any state discards whatever was in flight and relatches operands.
      if (ctrl_div) begin
        rem      <= '0;
        quo      <= magnitude(data_operandA);
        divisor  <= magnitude(data_operandB);
        negate   <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        div_zero <= b_zero;
        count    <= '0;
        state    <= b_zero ? DONE : RUN;
        busy     <= ~b_zero;
      end else begin
        case (state)
          RUN: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 6'd1;
            if (count == CNT_W'(ITER - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
          DONE: begin
            data_resultRDY <= 1'b1;
            data_result    <= div_zero ? '0 : (negate ? -quo : quo);
            data_exception <= div_zero;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_divider.sv
// tb/tb_multdiv_divider.sv - self-checking bench: vector table, random operands vs arithmetic model, abort and reset sequences
module tb_multdiv_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        e;
  } vec_t;

  vec_t vecs[13];

  multdiv_divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    if (b == 0) return 32'h0;
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    return q[31:0];
  endfunction

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic exp_e);
    int lat;
    int exp_lat;
    exp_lat = (b == 0) ? 1 : 33;
    @(negedge clock);
    ctrl_div = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) check({name, " busy"}, {31'b0, busy}, {31'b0, b != 0});
      if (data_resultRDY) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, data_result, exp_q);
    check({name, " exception"}, {31'b0, data_exception}, {31'b0, exp_e});
    @(posedge clock);
    #1;
    check({name, " rdy width"}, {31'b0, data_resultRDY}, 32'h0);
  endtask

  initial begin
    int rdy_count;
    int rdy_cyc;
    logic [31:0] ra, rb;

    vecs = '{
      '{32'd100,        32'd7,          32'd14,         1'b0},
      '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0},
      '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0},
      '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0},
      '{32'd5,          32'd0,          32'd0,          1'b1},
      '{32'd9,          32'd3,          32'd3,          1'b0},
      '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0},
      '{32'h80000000,   32'd1,          32'h80000000,   1'b0},
      '{32'd0,          32'd5,          32'd0,          1'b0},
      '{32'd7,          32'd100,        32'd0,          1'b0},
      '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0},
      '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0},
      '{32'h7FFFFFFF,   32'h80000000,   32'd0,          1'b0}
    };

    #1;
    check("reset result", data_result, 32'h0);
    check("reset exception", {31'b0, data_exception}, 32'h0);
    check("reset rdy", {31'b0, data_resultRDY}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].e);

    // Result must hold while operands wander with no start.
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
    #1;
    check("hold result", data_result, 32'h0);
    check("hold rdy", {31'b0, data_resultRDY}, 32'h0);
    check("hold busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 20);
        2: rb = (i == 2) ? 32'h0 : -$urandom_range(1, 1000);
        default: rb = {16'h0, 16'($urandom)};
      endcase
      run_div($sformatf("rand%0d", i), ra, rb, ref_quot(ra, rb), rb == 0);
    end

    // Restart mid-run: only the second operation completes.
    @(negedge clock);
    ctrl_div = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    rdy_count = 0;
    rdy_cyc = 0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 10) begin
        @(negedge clock);
        ctrl_div = 1'b1;
        data_operandA = 32'd81;
        data_operandB = 32'd9;
      end
      @(posedge clock);
      #1;
      if (n == 10) ctrl_div = 1'b0;
      if (n == 20) check("abort busy", {31'b0, busy}, 32'h1);
      if (data_resultRDY) begin
        rdy_count++;
        rdy_cyc = n;
      end
    end
    check("abort rdy count", rdy_count, 1);
    check("abort rdy cycle", rdy_cyc, 43);
    check("abort result", data_result, 32'd9);

    // Asynchronous reset mid-run.
    @(negedge clock);
    ctrl_div = 1'b1;
    data_operandA = 32'd64;
    data_operandB = 32'd8;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
    end
    check("pre-reset busy", {31'b0, busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset result", data_result, 32'h0);
    check("async reset exception", {31'b0, data_exception}, 32'h0);
    check("async reset rdy", {31'b0, data_resultRDY}, 32'h0);
    check("async reset busy", {31'b0, busy}, 32'h0);
    rdy_count = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clock);
      #1;
      if (n == 2) reset_n = 1'b1;
      if (data_resultRDY) rdy_count++;
    end
    check("reset no rdy", rdy_count, 0);
    run_div("after reset", 32'd64, 32'd8, 32'd8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
